// File: rtl/mux_arbiter_4x1.sv
// 4-way round-robin arbiter steering one 1-bit data path; grant 1 cycle after req seen in IDLE, zero-bubble handoff.
// No backpressure: owner holds until it drops req or its MAX_BURST-cycle burst expires; requesters wait on gnt.
module mux_arbiter_4x1 #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    output logic [3:0] gnt,
    output logic       S1,
    output logic       S0,
    output logic       busy,
    output logic       R
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] pick_start;
    logic [2:0] pick;
    logic       release_own;

    // Returns {found, index} of the first set request scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // While busy the scan always starts just past the owner, so a lone expiring owner wraps back to itself.
    assign pick_start  = (state_q == BUSY) ? sel_q + 2'd1 : ptr_q;
    assign pick        = rr_pick(req, pick_start);
    assign release_own = (state_q == BUSY) && (!req[sel_q] || cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        if (release_own) ptr_d = sel_q + 2'd1;
        if (state_q == IDLE || release_own) begin
            cnt_d = 4'd0;
            if (pick[2]) begin
                state_d = BUSY;
                sel_d   = pick[1:0];
                gnt_d   = 4'b0001 << pick[1:0];
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign S1   = sel_q[1];
    assign S0   = sel_q[0];
    assign busy = (state_q == BUSY);

    always_comb begin
        R = 1'b0;
        if (busy) begin
            case (sel_q)
                2'd0:    R = I0;
                2'd1:    R = I1;
                2'd2:    R = I2;
                default: R = I3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter_4x1.sv
// Directed bench for mux_arbiter_4x1 with MAX_BURST=4; expected values are hand-computed per scenario.
module tb_mux_arbiter_4x1;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       I0, I1, I2, I3;
    logic [3:0] gnt;
    logic       S1, S0, busy, R;

    int n_tests = 0;
    int n_fail  = 0;

    mux_arbiter_4x1 #(.MAX_BURST(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .I0   (I0),
        .I1   (I1),
        .I2   (I2),
        .I3   (I3),
        .gnt  (gnt),
        .S1   (S1),
        .S0   (S0),
        .busy (busy),
        .R    (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                             input logic e_busy);
        chk({tag, "_gnt"}, 8'(gnt), 8'(e_gnt));
        chk({tag, "_sel"}, 8'({S1, S0}), 8'(e_sel));
        chk({tag, "_busy"}, 8'(busy), 8'(e_busy));
    endtask

    logic [3:0] exp_gnt;

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        {I0, I1, I2, I3} = 4'b1111;
        step();
        step();
        chk_state("rst", 4'b0000, 2'd0, 1'b0);
        chk("rst_R", 8'(R), 8'd0);

        // First grant after reset, R follows I0
        reset = 1'b0;
        {I0, I1, I2, I3} = 4'b0000;
        req = 4'b0001;
        I0  = 1'b1;
        step();
        chk_state("first", 4'b0001, 2'd0, 1'b1);
        chk("first_R1", 8'(R), 8'd1);
        I0 = 1'b0;
        #1;
        chk("first_R0", 8'(R), 8'd0);

        // All requesting: 4-cycle bursts rotating with no idle gap
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            exp_gnt = 4'b0001 << ((k / 4) % 4);
            chk($sformatf("rr%0d_gnt", k), 8'(gnt), 8'(exp_gnt));
            chk($sformatf("rr%0d_busy", k), 8'(busy), 8'd1);
        end

        // Owner 0 drops after 2 cycles, requester 2 takes over next edge
        do_reset();
        req = 4'b0101;
        step();
        step();
        chk_state("drop_hold", 4'b0001, 2'd0, 1'b1);
        req = 4'b0100;
        step();
        chk_state("drop_hand", 4'b0100, 2'd2, 1'b1);
        I2 = 1'b1;
        #1;
        chk("drop_R1", 8'(R), 8'd1);
        I2 = 1'b0;
        #1;
        chk("drop_R0", 8'(R), 8'd0);

        // Lone requester 3 is re-granted across burst expiry without a gap
        do_reset();
        req = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_state($sformatf("lone%0d", k), 4'b1000, 2'd3, 1'b1);
        end

        // No preemption; request arriving in the expiry cycle wins the re-arbitration
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("nopre%0d_gnt", k), 8'(gnt), 8'(4'b0001));
        end
        step();
        chk_state("expire_hand", 4'b0010, 2'd1, 1'b1);

        // Reset mid-burst of owner 1, then fresh scan from index 0
        do_reset();
        req = 4'b0010;
        step();
        step();
        chk("mid_gnt", 8'(gnt), 8'(4'b0010));
        reset = 1'b1;
        req   = 4'b1010;
        step();
        chk_state("midrst", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        step();
        chk_state("midrst_next", 4'b0010, 2'd1, 1'b1);

        // Requests vanish: go idle, select holds, R forced low
        do_reset();
        req = 4'b0100;
        step();
        step();
        req = 4'b0000;
        {I0, I1, I2, I3} = 4'b1111;
        step();
        chk_state("idle", 4'b0000, 2'd2, 1'b0);
        chk("idle_R", 8'(R), 8'd0);

        // Pointer is now 3: from IDLE, req 1001 picks index 3 first
        req = 4'b1001;
        step();
        chk_state("ptr3", 4'b1000, 2'd3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_4x1.md
MUX_ARBITER_4X1 -- requirements
Module: mux_arbiter_4x1

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive grant cycles per ownership, legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared 1-bit mux path.
REQ-005 The block SHALL have ports I0, I1, I2, I3, input, 1 bit each: data from requesters 0..3.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have ports S1 and S0, output, 1 bit each: registered mux select; {S1,S0} equals the owner index.
REQ-008 The block SHALL have port busy, output, 1 bit: high when any grant is active.
REQ-009 The block SHALL have port R, output, 1 bit: selected data.

Function
REQ-010 The block SHALL implement two states, IDLE and BUSY, plus a 2-bit round-robin pointer ptr and a 4-bit burst counter cnt.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0000 and busy=0.
REQ-012 In IDLE with req!=0, the block SHALL pick the first set req bit scanning ptr, ptr+1, ... mod 4, then at the next edge enter BUSY with gnt one-hot on that index, {S1,S0}=index, busy=1, and cnt=0.
REQ-013 In BUSY, the owner SHALL keep the grant while req[owner]=1 and cnt<MAX_BURST-1, and cnt SHALL increment each cycle.
REQ-014 Release SHALL occur when req[owner]=0 or cnt==MAX_BURST-1 in BUSY.
REQ-015 On release, ptr SHALL be set to owner+1 mod 4, and the block SHALL re-arbitrate in the same cycle over the current req, scanning from owner+1.
REQ-016 Handoff after release SHALL have zero bubble: the new gnt is visible at the next edge.
REQ-017 If the expired owner is the only requester, it SHALL be re-granted with cnt=0 and gnt continuously high.
REQ-018 If req==0 at release, the block SHALL enter IDLE at the next edge with gnt=0000 and busy=0; {S1,S0} SHALL hold its last value.
REQ-019 A request that arrives in the same cycle as a release SHALL be included in that re-arbitration.
REQ-020 Requests from non-owners SHALL NOT preempt the owner before release.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 R SHALL be combinational: R = I[{S1,S0}] when busy=1, else 0.
REQ-023 Grant latency SHALL be 1 cycle from req sampled in IDLE to gnt asserted.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL set state=IDLE, ptr=0, cnt=0, gnt=0000, S1=0, S0=0, busy=0; R is therefore 0.
REQ-025 Reset SHALL take priority over all other activity, including mid-burst, and SHALL discard the current ownership.
REQ-026 The first arbitration after reset SHALL scan from index 0.

Verification
REQ-027 Reset, then req=0001, I0=1 -> one edge later: gnt=0001, S1S0=00, busy=1, R=1.
REQ-028 req=1111 held 20 cycles, MAX_BURST=4 -> gnt shows 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, 0001 again, with no idle cycle between owners.
REQ-029 Owner 0 drops req after 2 cycles while req[2]=1 -> next edge: gnt=0100, S1S0=10, R follows I2.
REQ-030 Only req[3] held 10 cycles -> gnt=1000 and busy=1 on every cycle, and S1S0=11 throughout.
REQ-031 Reset asserted on cycle 2 of a burst by owner 1, then released with req=1010 -> after reset: gnt=0000, busy=0; next grant is gnt=0010.
REQ-032 req falls to 0000 during a burst -> next edge: gnt=0000, busy=0, R=0 regardless of I0..I3.
